inst_mem_loader: RTL

//  Boot-time writer for the instruction memory, which the processor reads in every fetch.

---
 rtl/inst_mem_loader_if.sv | 21 ++
 rtl/inst_mem_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: byte-stream input and instruction-memory write port of the
// boot loader. The master modport is the loader's view. The slave modport is the
// environment's view: the stream source plus the memory.
interface inst_mem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: boot-time instruction-memory writer.
// The stream is a 16-bit word count (LSB first) followed by count x 4 data bytes.
// Data bytes are assembled little-endian into 32-bit words, and each word is written
// through the instruction-memory port. The processor is held in reset until the load
// completes.
// Optional feature: define CHECKSUM_EN to require one trailing checksum byte. The XOR
// of all length, data and checksum bytes must then be 8'h00.
module inst_mem_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    inst_mem_loader_if.master bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, LEN0 = 3'd1, LEN1 = 3'd2, DATA = 3'd3, CSUM = 3'd4, DONE = 3'd5, ERR = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, LEN0 = 3'd1, LEN1 = 3'd2, DATA = 3'd3, DONE = 3'd5, ERR = 3'd6
    } state_t;
`endif

    state_t      state_r;
    logic [7:0]  len_lo_r;
    logic [15:0] count_r;
    logic [23:0] asm_r;        // first three bytes of the word being assembled
    logic [1:0]  byte_cnt_r;   // byte position inside the current word
    logic        finish_r;     // last word is being written; completion follows

    logic        accept_s;
    logic [15:0] count_s;
    logic        oversize_s;
    logic        last_word_s;
    logic        may_start_s;
    logic [31:0] word_addr_s;

    // Handshake, length decode, end-of-image detection and write address
    always_comb begin
        accept_s    = bus.in_valid && bus.in_ready;
        count_s     = {bus.in_data, len_lo_r};
        oversize_s  = ({16'h0000, count_s} > (32'd1 << ADDR_W));
        last_word_s = ((32'(words_loaded) + 32'd1) == {16'h0000, count_r});
        may_start_s = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR));
        word_addr_s = BASE_ADDR + (32'(words_loaded) << 2);
    end

`ifdef CHECKSUM_EN
    logic [7:0] csum_r;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // Running XOR over every byte accepted in the current load
    always_ff @(posedge clk) begin
        if (!rst) begin
            csum_r <= 8'h00;
        end else if (may_start_s) begin
            csum_r <= 8'h00;
        end else if (accept_s) begin
            csum_r <= csum_add(csum_r, bus.in_data);
        end else begin
            csum_r <= csum_r;
        end
    end
`endif

    // Loader sequencer: stream parsing, word assembly, memory writes and status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            bus.in_ready <= 1'b0;
            bus.im_we    <= 1'b0;
            bus.im_addr  <= BASE_ADDR;
            bus.im_wdata <= 32'h0000_0000;
            cpu_hold     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= {(ADDR_W+1){1'b0}};
            len_lo_r     <= 8'h00;
            count_r      <= 16'h0000;
            asm_r        <= 24'h00_0000;
            byte_cnt_r   <= 2'd0;
            finish_r     <= 1'b0;
        end else begin
            bus.im_we <= 1'b0;
            case (state_r)
                IDLE, DONE, ERR: begin
                    if (may_start_s) begin
                        state_r      <= LEN0;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        words_loaded <= {(ADDR_W+1){1'b0}};
                        byte_cnt_r   <= 2'd0;
                        finish_r     <= 1'b0;
                    end
                end
                LEN0: begin
                    if (accept_s) begin
                        len_lo_r <= bus.in_data;
                        state_r  <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept_s) begin
                        count_r <= count_s;
                        if (oversize_s) begin
                            // The image does not fit: refuse it before any write happens
                            state_r      <= ERR;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b0;
                            err          <= 1'b1;
                        end else if (count_s == 16'h0000) begin
`ifdef CHECKSUM_EN
                            state_r <= CSUM;
`else
                            state_r      <= DONE;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            cpu_hold     <= 1'b0;
`endif
                        end else begin
                            state_r <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (finish_r) begin
                        finish_r <= 1'b0;
                        state_r  <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else if (accept_s) begin
                        asm_r      <= {bus.in_data, asm_r[23:8]};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            // in_ready stays high so the next word streams without a bubble
                            bus.im_we    <= 1'b1;
                            bus.im_addr  <= word_addr_s;
                            bus.im_wdata <= {bus.in_data, asm_r};
                            words_loaded <= words_loaded + {{ADDR_W{1'b0}}, 1'b1};
                            if (last_word_s) begin
`ifdef CHECKSUM_EN
                                state_r <= CSUM;
`else
                                bus.in_ready <= 1'b0;
                                finish_r     <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef CHECKSUM_EN
                CSUM: begin
                    if (accept_s) begin
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b0;
                        if (csum_add(csum_r, bus.in_data) == 8'h00) begin
                            state_r  <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state_r <= ERR;
                            err     <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_r      <= IDLE;
                    bus.in_ready <= 1'b0;
                    busy         <= 1'b0;
                    finish_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule
